// File: rtl/ram_init_pkg.sv
// Shared state encoding and sizing helper for the RAM initialisation sequencer.
package ram_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_W_DRAIN = 3'd2,
      ST_VERIFY  = 3'd3,
      ST_V_DRAIN = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam int DEF_N_ENTRIES = 32;

   // Width of a counter that must be able to hold the value n_entries.
   function automatic int idx_width(input int n_entries);
      return $clog2(n_entries + 1);
   endfunction

endpackage

// File: rtl/ram_init_checker.sv
// Readback checker: pairs each RAM read with its index one cycle later and
// latches the first ROM/RAM mismatch of a run.
module ram_init_checker #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr,
   input  logic          i_flush,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_idx,
   input  logic [DW-1:0] i_rom_data,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_err,
   output logic [AW-1:0] o_err_idx
);

   logic          r_cmp_vld_p1;
   logic [AW-1:0] r_cmp_idx_p1;
   logic          r_err;
   logic [AW-1:0] r_err_idx;
   logic          w_miss;

   // Read data returns one cycle after the request; a cancelled run drops the read in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) r_cmp_vld_p1 <= 1'b0;
      else                    r_cmp_vld_p1 <= i_rd_en;
   end

   // Index travelling alongside the returning read data.
   always_ff @(posedge i_clk) begin
      if (i_rd_en) r_cmp_idx_p1 <= i_rd_idx;
   end

   assign w_miss = r_cmp_vld_p1 && (i_rom_data != i_ram_rdata);

   // Sticky error: only the first mismatch since the last accepted start is recorded.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_err     <= 1'b0;
         r_err_idx <= '0;
      end else if (w_miss && !r_err) begin
         r_err     <= 1'b1;
         r_err_idx <= r_cmp_idx_p1;
      end
   end

   assign o_err     = r_err;
   assign o_err_idx = r_err_idx;

endmodule

// File: rtl/ram_init_sequencer.sv
// RAM initialisation sequencer: copies N_ENTRIES ROM words into RAM, one per
// cycle, then optionally reads everything back and compares it with the ROM.
module ram_init_sequencer
   import ram_init_pkg::*;
#(
   parameter int N_ENTRIES = DEF_N_ENTRIES,
   parameter int AW        = 5,
   parameter int DW        = 8,
   parameter int VERIFY    = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic          i_abort,
   output logic          o_rom_en,
   output logic [AW-1:0] o_rom_addr,
   input  logic [DW-1:0] i_rom_data,
   output logic          o_rom_to_ram,
   output logic          o_ram_we,
   output logic [AW-1:0] o_ram_waddr,
   output logic [DW-1:0] o_ram_wdata,
   output logic          o_ram_re,
   output logic [AW-1:0] o_ram_raddr,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [AW-1:0] o_err_idx
);

   localparam int               IDX_W     = idx_width(N_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENTRIES - 1);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(N_ENTRIES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [IDX_W-1:0] r_idx;
   logic             w_idx_last;
   logic             w_start_ok;
   logic             w_abort_run;
   logic [AW-1:0]    w_idx_addr;
   logic [AW-1:0]    w_idx_prev;

   assign w_idx_last  = (r_idx == LAST_IDX);
   assign w_idx_addr  = AW'(r_idx);
   assign w_idx_prev  = AW'(r_idx - IDX_W'(1));
   assign w_start_ok  = (r_state == ST_IDLE) && i_start;
   assign w_abort_run = (r_state != ST_IDLE) && i_abort;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // Index counter: zero on entry to every state, counts up while the state is held.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state == ST_IDLE) || (w_next != r_state)) r_idx <= '0;
      else                                                       r_idx <= r_idx + IDX_W'(1);
   end

   // Next-state decode; abort overrides everything once a run is under way.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (i_start)    w_next = ST_WRITE;
         ST_WRITE:   if (w_idx_last) w_next = ST_W_DRAIN;
         ST_W_DRAIN: w_next = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
         ST_VERIFY:  if (w_idx_last) w_next = ST_V_DRAIN;
         ST_V_DRAIN: w_next = ST_DONE;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
      if (w_abort_run) w_next = ST_IDLE;
   end

   // Output decode from registered state and index only; RAM writes lag ROM reads by one.
   always_comb begin
      o_rom_en     = 1'b0;
      o_rom_addr   = '0;
      o_rom_to_ram = 1'b0;
      o_ram_we     = 1'b0;
      o_ram_waddr  = '0;
      o_ram_re     = 1'b0;
      o_ram_raddr  = '0;
      o_done       = 1'b0;
      case (r_state)
         ST_WRITE: begin
            o_rom_en     = 1'b1;
            o_rom_addr   = w_idx_addr;
            o_rom_to_ram = 1'b1;
            if (r_idx != '0) begin
               o_ram_we    = 1'b1;
               o_ram_waddr = w_idx_prev;
            end
         end
         ST_W_DRAIN: begin
            o_rom_to_ram = 1'b1;
            o_ram_we     = 1'b1;
            o_ram_waddr  = LAST_ADDR;
         end
         ST_VERIFY: begin
            o_rom_en    = 1'b1;
            o_rom_addr  = w_idx_addr;
            o_ram_re    = 1'b1;
            o_ram_raddr = w_idx_addr;
         end
         ST_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   assign o_busy      = (r_state != ST_IDLE);
   assign o_ram_wdata = o_ram_we ? i_rom_data : '0;

   ram_init_checker #(
      .AW (AW),
      .DW (DW)
   ) u_checker (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_clr       (w_start_ok),
      .i_flush     (w_abort_run),
      .i_rd_en     (o_ram_re),
      .i_rd_idx    (o_ram_raddr),
      .i_rom_data  (i_rom_data),
      .i_ram_rdata (i_ram_rdata),
      .o_err       (o_err),
      .o_err_idx   (o_err_idx)
   );

endmodule

// File: tb/tb_ram_init_sequencer.sv
// Bench for ram_init_sequencer: ROM/RAM models, randomized contents, corruptions
// and abort points, checked against expectations derived from the cycle rules.
module tb_ram_init_sequencer;

   localparam int N  = 32;
   localparam int AW = 5;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: default parameters, verify enabled.
   logic          reset, start, abort;
   logic          rom_en, rom_to_ram, ram_we, ram_re, busy, done, err;
   logic [AW-1:0] rom_addr, ram_waddr, ram_raddr, err_idx;
   logic [DW-1:0] rom_data, ram_wdata, ram_rdata;

   ram_init_sequencer #(.N_ENTRIES(N), .AW(AW), .DW(DW), .VERIFY(1)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
      .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_rom_to_ram(rom_to_ram), .o_ram_we(ram_we), .o_ram_waddr(ram_waddr),
      .o_ram_wdata(ram_wdata), .o_ram_re(ram_re), .o_ram_raddr(ram_raddr),
      .i_ram_rdata(ram_rdata), .o_busy(busy), .o_done(done), .o_err(err),
      .o_err_idx(err_idx));

   // Small instance: one entry, no readback.
   logic          s_start, s_abort;
   logic          s_rom_en, s_rom_to_ram, s_ram_we, s_ram_re, s_busy, s_done, s_err;
   logic [0:0]    s_rom_addr, s_ram_waddr, s_ram_raddr, s_err_idx;
   logic [DW-1:0] s_rom_data, s_ram_wdata, s_ram_rdata;

   ram_init_sequencer #(.N_ENTRIES(1), .AW(1), .DW(DW), .VERIFY(0)) u_dut_small (
      .i_clk(clk), .i_reset(reset), .i_start(s_start), .i_abort(s_abort),
      .o_rom_en(s_rom_en), .o_rom_addr(s_rom_addr), .i_rom_data(s_rom_data),
      .o_rom_to_ram(s_rom_to_ram), .o_ram_we(s_ram_we), .o_ram_waddr(s_ram_waddr),
      .o_ram_wdata(s_ram_wdata), .o_ram_re(s_ram_re), .o_ram_raddr(s_ram_raddr),
      .i_ram_rdata(s_ram_rdata), .o_busy(s_busy), .o_done(s_done), .o_err(s_err),
      .o_err_idx(s_err_idx));

   // ROM/RAM model for the main instance; bad[i] corrupts the stored copy of word i.
   logic [DW-1:0] rom [N];
   logic [DW-1:0] ram [N];
   logic          bad [N];
   logic          clr_log;
   int            wr_cnt, re_cnt, wr_next;
   logic          wr_order_bad;

   always @(posedge clk) begin
      if (rom_en) rom_data <= rom[rom_addr];
      if (ram_re) ram_rdata <= ram[ram_raddr];
      if (clr_log) begin
         for (int i = 0; i < N; i++) ram[i] <= 8'hEE;
         wr_cnt       <= 0;
         re_cnt       <= 0;
         wr_next      <= 0;
         wr_order_bad <= 1'b0;
      end else begin
         if (ram_we) begin
            ram[ram_waddr] <= bad[ram_waddr] ? (ram_wdata ^ 8'h5A) : ram_wdata;
            wr_cnt         <= wr_cnt + 1;
            if (int'(ram_waddr) != wr_next) wr_order_bad <= 1'b1;
            wr_next        <= int'(ram_waddr) + 1;
         end
         if (ram_re) re_cnt <= re_cnt + 1;
      end
   end

   // Model for the single-entry instance.
   logic [DW-1:0] s_rom_word, s_ram_word;
   logic          s_clr;
   int            s_wr_cnt, s_re_cnt;
   logic [0:0]    s_wr_addr;

   always @(posedge clk) begin
      if (s_rom_en) s_rom_data <= s_rom_word;
      if (s_ram_re) s_ram_rdata <= s_ram_word;
      if (s_clr) begin
         s_wr_cnt   <= 0;
         s_re_cnt   <= 0;
         s_wr_addr  <= 1'b1;
         s_ram_word <= ~s_rom_word;
      end else begin
         if (s_ram_we) begin
            s_ram_word <= s_ram_wdata;
            s_wr_cnt   <= s_wr_cnt + 1;
            s_wr_addr  <= s_ram_waddr;
         end
         if (s_ram_re) s_re_cnt <= s_re_cnt + 1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({busy, done, err, rom_en, ram_we, ram_re, rom_to_ram,
                  err_idx, rom_addr, ram_waddr, ram_raddr, ram_wdata});
   endfunction

   function automatic logic [63:0] s_outs();
      return 64'({s_busy, s_done, s_err, s_rom_en, s_ram_we, s_ram_re, s_rom_to_ram,
                  s_err_idx, s_rom_addr, s_ram_waddr, s_ram_raddr, s_ram_wdata});
   endfunction

   // Smallest corrupted index not above 'upto', or -1.
   function automatic int first_bad(input int upto);
      for (int i = 0; i <= upto && i < N; i++) if (bad[i]) return i;
      return -1;
   endfunction

   // Number of RAM words (below 'cnt') that differ from what the copy should have stored.
   function automatic int ram_diffs(input int cnt);
      int d = 0;
      for (int i = 0; i < cnt; i++)
         if (ram[i] !== (bad[i] ? (rom[i] ^ 8'h5A) : rom[i])) d++;
      return d;
   endfunction

   int r_done_cyc, r_n_done, r_idle_cyc, r_first_we, r_last_we;
   logic r_err_c1;

   // One run of the main instance. Cycle c is observed c negedges after the edge
   // that samples start; abort/reset raised in cycle c are sampled at the end of it.
   task automatic run(input int abort_at, input int reset_at, input bit hold);
      clr_log = 1'b1;
      @(negedge clk);
      clr_log = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      r_done_cyc = -1; r_n_done = 0; r_idle_cyc = -1; r_first_we = -1; r_last_we = -1;
      r_err_c1 = 1'bx;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         abort = 1'b0;
         if (reset) begin
            check_eq("rst_outs_midrun", outs(), 64'd0);
            reset = 1'b0;
         end
         if (c == 1) r_err_c1 = err;
         if (done) begin
            r_n_done++;
            if (r_done_cyc < 0) r_done_cyc = c;
         end
         if (ram_we) begin
            if (r_first_we < 0) r_first_we = c;
            r_last_we = c;
         end
         if (!busy) begin
            r_idle_cyc = c;
            break;
         end
         if (c == abort_at) abort = 1'b1;
         if (c == reset_at) reset = 1'b1;
      end
   endtask

   initial begin
      int a, k, ef, c2, nd2, idle2, s_done_cyc, s_idle_cyc;
      reset = 1'b1; start = 1'b0; abort = 1'b0; clr_log = 1'b0;
      s_start = 1'b0; s_abort = 1'b0; s_clr = 1'b1; s_rom_word = 8'h00;
      for (int i = 0; i < N; i++) begin
         rom[i] = DW'(i + 16);
         bad[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_eq("reset_outs", outs(), 64'd0);
      check_eq("reset_outs_small", s_outs(), 64'd0);
      reset = 1'b0;
      s_clr = 1'b0;
      @(negedge clk);

      // Plain copy + verify, ROM word i = i + 10h.
      run(0, 0, 1'b0);
      check_eq("done_cycle", r_done_cyc, 2 * N + 3);
      check_eq("done_pulses", r_n_done, 1);
      check_eq("idle_cycle", r_idle_cyc, 2 * N + 4);
      check_eq("we_count", wr_cnt, N);
      check_eq("we_window", {r_first_we, r_last_we}, {32'd2, 32'(N + 1)});
      check_eq("we_order", wr_order_bad, 1'b0);
      check_eq("re_count", re_cnt, N);
      for (int i = 0; i < N; i++) check_eq($sformatf("ram[%0d]", i), ram[i], DW'(i + 16));
      check_eq("err_clean", {err, err_idx}, 0);

      // Corrupted writes to 5 and 9: first mismatch reported.
      bad[5] = 1'b1; bad[9] = 1'b1;
      run(0, 0, 1'b0);
      check_eq("err_two_bad", {err, err_idx}, {1'b1, 5'd5});
      check_eq("done_cycle_bad", r_done_cyc, 2 * N + 3);
      bad[5] = 1'b0; bad[9] = 1'b0;
      run(0, 0, 1'b0);
      check_eq("err_cleared_on_start", r_err_c1, 1'b0);
      check_eq("err_after_clean", {err, err_idx}, 0);

      // Random ROM contents and random corruption sets.
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < N; i++) begin
            rom[i] = DW'($urandom);
            bad[i] = ($urandom_range(0, 11) == 0);
         end
         run(0, 0, 1'b0);
         ef = first_bad(N - 1);
         check_eq($sformatf("rand%0d_err", it), {err, err_idx},
                  {ef >= 0, (ef >= 0) ? AW'(ef) : AW'(0)});
         check_eq($sformatf("rand%0d_ram", it), ram_diffs(N), 0);
         check_eq($sformatf("rand%0d_done", it), r_done_cyc, 2 * N + 3);
      end
      for (int i = 0; i < N; i++) begin
         rom[i] = DW'(i + 16);
         bad[i] = 1'b0;
      end

      // Abort raised in the cycle presenting the write to address 7.
      run(9, 0, 1'b0);
      check_eq("abort_idle", r_idle_cyc, 10);
      check_eq("abort_no_done", r_n_done, 0);
      check_eq("abort_we_count", wr_cnt, 8);
      check_eq("abort_we_last", {wr_order_bad, wr_next}, {1'b0, 32'd8});
      check_eq("abort_ram", ram_diffs(8), 0);

      // Random abort during WRITE: writes presented up to the abort cycle complete.
      a = $urandom_range(2, N + 1);
      run(a, 0, 1'b0);
      check_eq("rabort_we_count", wr_cnt, a - 1);
      check_eq("rabort_idle", {r_idle_cyc, r_n_done}, {32'(a + 1), 32'd0});

      // Random abort during VERIFY with one corrupted word: index k is judged in cycle N+3+k.
      k = $urandom_range(0, N - 1);
      bad[k] = 1'b1;
      a = $urandom_range(N + 2, 2 * N + 2);
      run(a, 0, 1'b0);
      ef = (N + 3 + k <= a) ? k : -1;
      check_eq("vabort_err", {err, err_idx}, {ef >= 0, (ef >= 0) ? AW'(ef) : AW'(0)});
      check_eq("vabort_idle", {r_idle_cyc, r_n_done}, {32'(a + 1), 32'd0});
      bad[k] = 1'b0;

      // Start held high: ignored while busy, a new run follows DONE.
      run(0, 0, 1'b1);
      check_eq("hold_done_cycle", r_done_cyc, 2 * N + 3);
      check_eq("hold_done_pulses", r_n_done, 1);
      check_eq("hold_idle", r_idle_cyc, 2 * N + 4);
      @(negedge clk);
      check_eq("hold_restart", busy, 1'b1);
      start = 1'b0;
      nd2 = 0; idle2 = -1;
      for (c2 = 2 * N + 6; c2 <= 400; c2++) begin
         @(negedge clk);
         if (done) nd2++;
         if (!busy) begin
            idle2 = c2;
            break;
         end
      end
      check_eq("hold_run2_idle", idle2, 2 * (2 * N + 4));
      check_eq("hold_run2_done", nd2, 1);
      check_eq("hold_we_total", wr_cnt, 2 * N);

      // Reset mid-VERIFY, then a clean full sequence.
      run(0, 40, 1'b0);
      check_eq("reset_run_idle", {r_idle_cyc, r_n_done}, {32'd41, 32'd0});
      run(0, 0, 1'b0);
      check_eq("post_reset_done", r_done_cyc, 2 * N + 3);
      check_eq("post_reset_err", {err, err_idx}, 0);
      check_eq("post_reset_ram", {wr_cnt, ram_diffs(N)}, {32'(N), 32'd0});

      // Single entry, no readback.
      s_rom_word = DW'($urandom);
      s_clr = 1'b1;
      @(negedge clk);
      s_clr   = 1'b0;
      s_start = 1'b1;
      @(posedge clk);
      s_done_cyc = -1; s_idle_cyc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_done && s_done_cyc < 0) s_done_cyc = c;
         if (!s_busy) begin
            s_idle_cyc = c;
            break;
         end
      end
      check_eq("small_done_cycle", s_done_cyc, 3);
      check_eq("small_idle", s_idle_cyc, 4);
      check_eq("small_writes", {s_wr_cnt, 31'd0, s_wr_addr}, {32'd1, 32'd0});
      check_eq("small_data", s_ram_word, s_rom_word);
      check_eq("small_no_read", s_re_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
